// File: rtl/cpu_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Holds the forwarding-select encoding, the per-stage shadow record and
// the "does this stage produce register r" predicate used by both the
// EX forwarding muxes and the optional WB->ID bypass.
package cpu_hazard_pkg;

    localparam int unsigned HZ_REG_ADDR_W = 5;

    // Forwarding mux select for the EX operands
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Shadow copy of what an instruction in a stage reads and writes
    typedef struct packed {
        logic                     valid;
        logic [HZ_REG_ADDR_W-1:0] rs1;
        logic [HZ_REG_ADDR_W-1:0] rs2;
        logic [HZ_REG_ADDR_W-1:0] rd;
        logic                     regwrite;
        logic                     memread;
    } stage_info_t;

    localparam int unsigned HZ_STAGE_W = $bits(stage_info_t);

    // All-zero record: an empty stage / pipeline bubble
    localparam stage_info_t STAGE_BUBBLE = {HZ_STAGE_W{1'b0}};

    // Register x0 is hard-wired zero and never forwarded
    localparam logic [HZ_REG_ADDR_W-1:0] HZ_X0 = {HZ_REG_ADDR_W{1'b0}};

    // True when the stage will write a live value into register r
    function automatic logic writes_reg(input stage_info_t s,
                                        input logic [HZ_REG_ADDR_W-1:0] r);
        return s.valid && s.regwrite && (s.rd != HZ_X0) && (s.rd == r);
    endfunction

    // Pick the youngest producer of rs; MEM is younger than WB
    function automatic fwd_sel_e fwd_select(input stage_info_t mem_s,
                                            input stage_info_t wb_s,
                                            input logic [HZ_REG_ADDR_W-1:0] rs);
        fwd_sel_e sel;
        if (writes_reg(mem_s, rs)) begin
            sel = FWD_MEM;
        end else if (writes_reg(wb_s, rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline <-> hazard/forwarding controller bundle.
// master: the pipeline datapath driving ID info and stage controls.
// slave : the hazard_fwd_unit consuming them and returning mux/stall/flush.
interface hazard_fwd_unit_if #(
    parameter int unsigned REG_ADDR_W = cpu_hazard_pkg::HZ_REG_ADDR_W
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  ex_branch_taken;
    logic                  mem_stall;

    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  stall_if_id;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  id_byp_a;
    logic                  id_byp_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_regwrite, id_memread, ex_branch_taken, mem_stall,
        input  fwd_a, fwd_b, stall_if_id, flush_if_id, flush_id_ex,
        input  id_byp_a, id_byp_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_regwrite, id_memread, ex_branch_taken, mem_stall,
        output fwd_a, fwd_b, stall_if_id, flush_if_id, flush_id_ex,
        output id_byp_a, id_byp_b
    );
endinterface

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: mirrors the real pipeline register beside it.
// Holds while the data memory is waiting, loads a bubble when asked,
// otherwise takes the record from the previous stage.
module hazard_stage_reg
    import cpu_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  stage_info_t d_i,
    output stage_info_t q_o
);

    stage_info_t info_q;
    stage_info_t info_d;

    // Next-state select: hold has priority so a frozen pipeline loses nothing
    always_comb begin
        info_d = info_q;
        if (hold_i) begin
            info_d = info_q;
        end else if (bubble_i) begin
            info_d = STAGE_BUBBLE;
        end else begin
            info_d = d_i;
        end
    end

    // Stage register, empty (valid=0) out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            info_q <= STAGE_BUBBLE;
        end else begin
            info_q <= info_d;
        end
    end

    assign q_o = info_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline.
// Shadows EX/MEM/WB destination/source info, drives the EX operand
// forwarding selects, load-use stall/bubble and taken-branch flushes.
// Optional feature macro: HAZARD_ID_BYPASS_EN enables the WB->ID bypass
// outputs (for a register file that is not write-first); otherwise
// id_byp_a/id_byp_b are tied low.
// REG_ADDR_W must match cpu_hazard_pkg::HZ_REG_ADDR_W; LOAD_USE_BUBBLES is 1..3.
// Stall/flush outputs are not masked by mem_stall; the pipeline qualifies
// them with its own advance condition.
module hazard_fwd_unit
    import cpu_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W       = HZ_REG_ADDR_W,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_fwd_unit_if.slave  bus
);

    localparam int unsigned     CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_ZERO = 2'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 2'd1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_USE_BUBBLES - 32'd1);

    logic [REG_ADDR_W-1:0] id_rs1_s;
    logic [REG_ADDR_W-1:0] id_rs2_s;
    logic [REG_ADDR_W-1:0] id_rd_s;
    stage_info_t           id_info_s;
    stage_info_t           ex_q;
    stage_info_t           mem_q;
    stage_info_t           wb_q;

    logic                  advance_s;
    logic                  hazard_s;
    logic                  branch_s;
    logic                  stall_s;
    logic                  flush_id_ex_s;
    logic                  byp_a_s;
    logic                  byp_b_s;
    fwd_sel_e              fwd_a_s;
    fwd_sel_e              fwd_b_s;
    logic [CNT_W-1:0]      bubble_cnt_q;
    logic [CNT_W-1:0]      bubble_cnt_d;
    logic                  unused_wb_fields_s;

    assign id_rs1_s  = bus.id_rs1;
    assign id_rs2_s  = bus.id_rs2;
    assign id_rd_s   = bus.id_rd;
    assign advance_s = !bus.mem_stall;

    // Pack the ID-stage instruction into a shadow record
    always_comb begin
        id_info_s          = STAGE_BUBBLE;
        id_info_s.valid    = bus.id_valid;
        id_info_s.rs1      = id_rs1_s;
        id_info_s.rs2      = id_rs2_s;
        id_info_s.rd       = id_rd_s;
        id_info_s.regwrite = bus.id_regwrite;
        id_info_s.memread  = bus.id_memread;
    end

    hazard_stage_reg u_ex_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (bus.mem_stall),
        .bubble_i (flush_id_ex_s),
        .d_i      (id_info_s),
        .q_o      (ex_q)
    );

    hazard_stage_reg u_mem_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (bus.mem_stall),
        .bubble_i (1'b0),
        .d_i      (ex_q),
        .q_o      (mem_q)
    );

    hazard_stage_reg u_wb_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (bus.mem_stall),
        .bubble_i (1'b0),
        .d_i      (mem_q),
        .q_o      (wb_q)
    );

    // WB only needs rd/regwrite/valid; its source fields are shadow baggage
    assign unused_wb_fields_s = ^{wb_q.rs1, wb_q.rs2, wb_q.memread};

    // EX operand forwarding, zero latency from the current shadow stages
    always_comb begin
        fwd_a_s = fwd_select(mem_q, wb_q, ex_q.rs1);
        fwd_b_s = fwd_select(mem_q, wb_q, ex_q.rs2);
    end

    // Load in EX whose result the ID instruction needs next cycle
    always_comb begin
        hazard_s = 1'b0;
        if (ex_q.valid && ex_q.memread && (ex_q.rd != HZ_X0) && bus.id_valid) begin
            hazard_s = (bus.id_uses_rs1 && (id_rs1_s == ex_q.rd)) ||
                       (bus.id_uses_rs2 && (id_rs2_s == ex_q.rd));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign branch_s = bus.ex_branch_taken && ex_q.valid;

    // Stall/flush decode: a taken branch kills the younger instructions, so it overrides any stall
    always_comb begin
        stall_s       = 1'b0;
        flush_id_ex_s = 1'b0;
        if (branch_s) begin
            stall_s       = 1'b0;
            flush_id_ex_s = 1'b1;
        end else if (hazard_s || (bubble_cnt_q != CNT_ZERO)) begin
            stall_s       = 1'b1;
            flush_id_ex_s = 1'b1;
        end else begin
            stall_s       = 1'b0;
            flush_id_ex_s = 1'b0;
        end
    end

    // Remaining-bubble count after the current one; only moves on advancing cycles
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!advance_s) begin
            bubble_cnt_d = bubble_cnt_q;
        end else if (branch_s) begin
            bubble_cnt_d = CNT_ZERO;
        end else if (bubble_cnt_q != CNT_ZERO) begin
            bubble_cnt_d = bubble_cnt_q - CNT_ONE;
        end else if (hazard_s) begin
            bubble_cnt_d = CNT_LOAD;
        end else begin
            bubble_cnt_d = CNT_ZERO;
        end
    end

    // Bubble counter register; reset aborts any stall in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= CNT_ZERO;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

`ifdef HAZARD_ID_BYPASS_EN
    // WB->ID bypass for a register file that returns the old value on same-cycle write
    always_comb begin
        byp_a_s = writes_reg(wb_q, id_rs1_s) && bus.id_uses_rs1;
        byp_b_s = writes_reg(wb_q, id_rs2_s) && bus.id_uses_rs2;
    end
`else
    // Register file is write-first; no ID bypass needed
    always_comb begin
        byp_a_s = 1'b0;
        byp_b_s = 1'b0;
    end
`endif

    assign bus.fwd_a       = fwd_a_s;
    assign bus.fwd_b       = fwd_b_s;
    assign bus.stall_if_id = stall_s;
    assign bus.flush_if_id = branch_s;
    assign bus.flush_id_ex = flush_id_ex_s;
    assign bus.id_byp_a    = byp_a_s;
    assign bus.id_byp_b    = byp_b_s;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: a vector table drives a BUBBLES=1 instance
// cycle by cycle (the bench plays the pipeline, re-presenting ID on stalls),
// and a hand sequence drives a BUBBLES=2 instance through mem_stall and a
// mid-stall reset. Expected values go into a scoreboard queue when driven.
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.REG_ADDR_W(5)) bus1 ();
    hazard_fwd_unit_if #(.REG_ADDR_W(5)) bus2 ();

    hazard_fwd_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    hazard_fwd_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

`ifdef HAZARD_ID_BYPASS_EN
    localparam logic BYP_EN = 1'b1;
`else
    localparam logic BYP_EN = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw, mr, br, ms;
        logic [1:0] fa, fb;
        logic       st, fif, fex, ba, bb;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] fa, fb;
        logic       st, fif, fex, ba, bb;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic br, input logic ms,
                                input logic [1:0] fa, input logic [1:0] fb, input logic st,
                                input logic fif, input logic fex, input logic ba, input logic bb);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd;
        r.rw = rw; r.mr = mr; r.br = br; r.ms = ms;
        r.fa = fa; r.fb = fb; r.st = st; r.fif = fif; r.fex = fex; r.ba = ba; r.bb = bb;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, req);
        end
    endtask

    task automatic drive1(input int idx, input vec_t v);
        exp_t e;
        bus1.id_valid = v.v;     bus1.id_rs1 = v.rs1;     bus1.id_uses_rs1 = v.u1;
        bus1.id_rs2 = v.rs2;     bus1.id_uses_rs2 = v.u2; bus1.id_rd = v.rd;
        bus1.id_regwrite = v.rw; bus1.id_memread = v.mr;
        bus1.ex_branch_taken = v.br; bus1.mem_stall = v.ms;
        e.idx = idx; e.fa = v.fa; e.fb = v.fb; e.st = v.st; e.fif = v.fif; e.fex = v.fex;
        e.ba = v.ba & BYP_EN; e.bb = v.bb & BYP_EN;
        sb_q.push_back(e);
    endtask

    task automatic drive2(input logic v, input logic [4:0] rs1, input logic [4:0] rd,
                          input logic mr, input logic ms);
        bus2.id_valid = v;     bus2.id_rs1 = rs1;      bus2.id_uses_rs1 = v;
        bus2.id_rs2 = 5'd0;    bus2.id_uses_rs2 = 1'b0; bus2.id_rd = rd;
        bus2.id_regwrite = v;  bus2.id_memread = mr;
        bus2.ex_branch_taken = 1'b0; bus2.mem_stall = ms;
    endtask

    // Pop the oldest expectation and compare against the chosen instance
    task automatic sample(input logic sel2);
        exp_t e;
        logic [1:0] fa, fb;
        logic st, fif, fex, ba, bb;
        if (sel2) begin
            fa = bus2.fwd_a; fb = bus2.fwd_b; st = bus2.stall_if_id; fif = bus2.flush_if_id;
            fex = bus2.flush_id_ex; ba = bus2.id_byp_a; bb = bus2.id_byp_b;
        end else begin
            fa = bus1.fwd_a; fb = bus1.fwd_b; st = bus1.stall_if_id; fif = bus1.flush_if_id;
            fex = bus1.flush_id_ex; ba = bus1.id_byp_a; bb = bus1.id_byp_b;
        end
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb_q.pop_front();
            chk("fwd_a", e.idx, fa, e.fa);
            chk("fwd_b", e.idx, fb, e.fb);
            chk("stall_if_id", e.idx, {1'b0, st}, {1'b0, e.st});
            chk("flush_if_id", e.idx, {1'b0, fif}, {1'b0, e.fif});
            chk("flush_id_ex", e.idx, {1'b0, fex}, {1'b0, e.fex});
            chk("id_byp_a", e.idx, {1'b0, ba}, {1'b0, e.ba});
            chk("id_byp_b", e.idx, {1'b0, bb}, {1'b0, e.bb});
        end
    endtask

    // One BUBBLES=2 cycle: drive ID, expect only stall/bubble (forwarding stays 00)
    task automatic step2(input int idx, input logic v, input logic [4:0] rs1, input logic [4:0] rd,
                         input logic mr, input logic ms, input logic st, input logic fex, input logic ba);
        exp_t e;
        @(posedge clk); #1;
        drive2(v, rs1, rd, mr, ms);
        e.idx = 100 + idx; e.fa = 2'b00; e.fb = 2'b00; e.st = st; e.fif = 1'b0; e.fex = fex;
        e.ba = ba & BYP_EN; e.bb = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        sample(1'b1);
    endtask

    initial begin
        //            v  rs1  u1 rs2  u2 rd   rw mr br ms   fa     fb     st fif fex ba bb
        vecs[0]  = mk(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 5'd5, 1, 5'd4, 1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 5'd9, 1, 5'd9, 1, 5'd7, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 5'd8, 1, 5'd8, 1, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 5'd1, 1, 5'd7, 1, 5'd10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 5'd10, 1, 5'd7, 1, 5'd12, 1, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 1);
        vecs[6]  = mk(1, 5'd3, 1, 5'd3, 1, 5'd0, 1, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 5'd1, 1, 5'd3, 1, 5'd13, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);
        vecs[10] = mk(1, 5'd1, 1, 5'd3, 1, 5'd13, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 5'd4, 1, 5'd0, 0, 5'd14, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0);
        vecs[13] = mk(1, 5'd4, 1, 5'd0, 0, 5'd15, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 5'd4, 1, 5'd4, 0, 5'd0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0);
        vecs[15] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        rst_n  = 1'b0;
        rst2_n = 1'b0;
        drive1(-1, mk(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        drive2(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample(1'b0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // Main table: forwarding priorities, x0, load-use, branch override
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive1(i, vecs[i]);
            @(negedge clk);
            sample(1'b0);
        end

        // BUBBLES=2 with a 3-cycle memory wait inside the stall: 5 stall cycles
        step2(0, 1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step2(1, 1'b1, 5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step2(2, 1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step2(3, 1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step2(4, 1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step2(5, 1'b1, 5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step2(6, 1'b1, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step2(7, 1'b1, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step2(8, 1'b1, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step2(9, 1'b1, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of the second stall cycle: outputs drop at once
        #2;
        rst2_n = 1'b0;
        #1;
        chk("rst_mid_stall", 200, {1'b0, bus2.stall_if_id}, 2'b00);
        chk("rst_mid_flush_id_ex", 200, {1'b0, bus2.flush_id_ex}, 2'b00);
        chk("rst_mid_flush_if_id", 200, {1'b0, bus2.flush_if_id}, 2'b00);
        chk("rst_mid_fwd_a", 200, bus2.fwd_a, 2'b00);
        chk("rst_mid_fwd_b", 200, bus2.fwd_b, 2'b00);
        chk("rst_mid_byp_a", 200, {1'b0, bus2.id_byp_a}, 2'b00);
        @(negedge clk);
        rst2_n = 1'b1;
        step2(10, 1'b1, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step2(11, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left actual=%0d required=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
